// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle control path:
// opcodes, FSM state encoding and datapath select codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    S_BOOT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JALR_PC  = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RS1   = 2'b10;

  localparam logic [1:0] SB_RS2  = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;

  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_MEM    = 2'b01;
  localparam logic [1:0] RS_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

endpackage

// File: rtl/ctrl_imm_decode.sv
// Opcode to immediate-format mapping, shared by the
// single-cycle and multi-cycle decoders.
module ctrl_imm_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    unique case (1'b1)
      (op == OP_STORE): imm_src = IMM_S;
      (op == OP_BR):    imm_src = IMM_B;
      (op == OP_JAL):   imm_src = IMM_J;
      default:          imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences the shared ALU and
// unified memory port, with a watchdog on stalled accesses.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_retired,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  localparam logic [CNT_W-1:0] LIMIT_M1 =
    CNT_W'(WAIT_LIMIT - 1);

  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] cnt;
  logic             waiting;
  logic             wd_hit;
  logic             dec_bad;

  ctrl_imm_decode u_imm (
    .op      (op),
    .imm_src (imm_src)
  );

  assign waiting = (state == S_FETCH ||
                    state == S_MEMREAD ||
                    state == S_MEMWRITE) && !mem_ready;
  assign wd_hit  = waiting && (cnt == LIMIT_M1);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_BOOT;
      cnt        <= '0;
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)
        cnt <= '0;
      else if (waiting)
        cnt <= cnt + CNT_W'(1);
      if (dec_bad)
        illegal_op <= 1'b1;
      if (wd_hit)
        bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_n       = state;
    dec_bad       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    alu_src_a     = SA_PC;
    alu_src_b     = SB_RS2;
    alu_op        = ALU_ADD;
    result_src    = RS_ALUOUT;
    unique case (state)
      S_BOOT: state_n = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SB_FOUR;
        result_src = RS_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SA_OLDPC;
        alu_src_b = SB_IMM;
        unique case (1'b1)
          (op == OP_LOAD),
          (op == OP_STORE): state_n = S_MEMADR;
          (op == OP_R):     state_n = S_EXECR;
          (op == OP_I):     state_n = S_EXECI;
          (op == OP_BR):    state_n = S_BRANCH;
          (op == OP_JAL):   state_n = S_JAL;
          (op == OP_JALR):  state_n = S_JALR;
          default: begin
            state_n = S_TRAP;
            dec_bad = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SA_RS1;
        alu_src_b = SB_IMM;
        state_n = (op == OP_LOAD) ? S_MEMREAD
                                  : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RS_MEM;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_n       = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_n       = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = SA_RS1;
        alu_op    = ALU_FN;
        state_n   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SA_RS1;
        alu_src_b = SB_IMM;
        alu_op    = ALU_FN;
        state_n   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_n       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = SA_RS1;
        alu_op        = ALU_BR;
        pc_write      = branch_taken;
        instr_retired = 1'b1;
        state_n       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SA_OLDPC;
        alu_src_b = SB_FOUR;
        pc_write  = 1'b1;
        state_n   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = SA_RS1;
        alu_src_b = SB_IMM;
        state_n   = S_JALR_PC;
      end
      S_JALR_PC: begin
        alu_src_a = SA_OLDPC;
        alu_src_b = SB_FOUR;
        pc_write  = 1'b1;
        state_n   = S_ALUWB;
      end
      S_TRAP: state_n = S_TRAP;
      default: state_n = S_TRAP;
    endcase
    // completion wins because wd_hit requires !mem_ready
    if (wd_hit) state_n = S_TRAP;
  end

endmodule
